riscv_aes_result_buffer: RTL and testbench

// - Return path of the RISC-V AES unit: captures the 128-bit AES engine result on completion and

---
 rtl/riscv_aes_result_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_riscv_aes_result_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_aes_result_buffer.sv
// riscv_aes_result_buffer
// Return path of the RISC-V AES unit. It captures the 128-bit engine result
// on completion and lets the core read it back as four 32-bit words.
// Word map: addr0=result[127:96], addr1=[95:64], addr2=[63:32], addr3=[31:0].
// Core reads stall while the engine is BUSY. Once all four words have been
// read, the FSM returns to IDLE and the buffer is retained.
// Optional feature macro: RISCV_AES_RESULT_TIMEOUT_EN adds a BUSY watchdog
// that gives up after TIMEOUT_CYCLES BUSY cycles and raises a sticky timeout_o.
module riscv_aes_result_buffer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     test_en_i,
  input  logic                                     aes_start_i,
  input  logic                                     aes_done_i,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    aes_result_i,
  input  logic [ADDR_WIDTH-1:0]                    raddr_i,
  input  logic                                     ren_i,
  output logic [DATA_WIDTH-1:0]                    rdata_o,
  output logic                                     rvalid_o,
  output logic                                     stall_o,
  output logic                                     busy_o,
  output logic                                     result_valid_o,
  output logic                                     timeout_o
);

  localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned RES_W = WORDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [RES_W-1:0]       buf_q, buf_d;
  logic [WORDS-1:0]       mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   busy_q, busy_d;
  logic                   rv_q, rv_d;
  logic                   timeout_q;

  logic                   read_acc_s;
  logic                   enter_busy_s;
  logic                   timeout_hit_s;
  logic [WORDS-1:0]       raddr_oh_s;
  logic [WORDS-1:0]       mask_set_s;
  logic [DATA_WIDTH-1:0]  words_s [WORDS];

  // A zero watchdog limit is meaningless; reject it at elaboration.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  // Word 0 is the most significant slice of the result.
  for (genvar w = 0; w < WORDS; w++) begin : g_words
    assign words_s[w] = buf_q[(WORDS-1-w)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign read_acc_s   = ren_i && (state_q != ST_BUSY);
  assign enter_busy_s = aes_start_i && (state_q != ST_BUSY);
  assign raddr_oh_s   = {{(WORDS-1){1'b0}}, 1'b1} << raddr_i;
  assign mask_set_s   = mask_q | raddr_oh_s;

`ifdef RISCV_AES_RESULT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  // The cycle before this check has counted TIMEOUT_CYCLES-1 BUSY cycles,
  // so this is the last BUSY cycle allowed. A done in this cycle still wins.
  assign timeout_hit_s = (state_q == ST_BUSY) && !aes_done_i &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog next state: restart on BUSY entry, count BUSY cycles, and make the flag sticky.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (enter_busy_s) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (timeout_hit_s) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_q     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (aes_start_i) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (aes_done_i) begin
          state_d = ST_READY;
        end else if (timeout_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_READY: begin
        if (aes_start_i) begin
          state_d = ST_BUSY;
        end else if (read_acc_s && (&mask_set_s)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next state: buffer, read mask, read port and status flags.
  always_comb begin
    buf_d    = buf_q;
    mask_d   = mask_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (test_en_i) begin
      buf_d = {RES_W{1'b1}};
    end else if ((state_q == ST_BUSY) && aes_done_i) begin
      buf_d = aes_result_i;
    end else begin
      buf_d = buf_q;
    end
    // A start discards progress. Reads made while IDLE do not count toward the mask.
    if (enter_busy_s) begin
      mask_d = '0;
    end else if ((state_q == ST_READY) && read_acc_s) begin
      mask_d = mask_set_s;
    end else begin
      mask_d = mask_q;
    end
    // The accepted read uses the current buffer, even when a capture or start happens in the same cycle.
    if (read_acc_s) begin
      rdata_d  = words_s[raddr_i];
      rvalid_d = 1'b1;
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
    busy_d = (state_d == ST_BUSY);
    rv_d   = (state_d == ST_READY);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
    end
  end

  assign rdata_o        = rdata_q;
  assign rvalid_o       = rvalid_q;
  assign busy_o         = busy_q;
  assign result_valid_o = rv_q;
  assign timeout_o      = timeout_q;
  assign stall_o        = ren_i && (state_q == ST_BUSY);

endmodule

// File: tb/tb_riscv_aes_result_buffer.sv
// Testbench for riscv_aes_result_buffer: directed scenarios plus random traffic,
// checked against a behavioural model through a read-data scoreboard.
module tb_riscv_aes_result_buffer;

  localparam int TO_CYCLES = 64;
`ifdef RISCV_AES_RESULT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_BUSY  = 1;
  localparam int M_READY = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         test_en_i, aes_start_i, aes_done_i, ren_i;
  logic [127:0] aes_result_i;
  logic [1:0]   raddr_i;
  logic [31:0]  rdata_o;
  logic         rvalid_o, stall_o, busy_o, result_valid_o, timeout_o;

  always #5 clk = ~clk;

  riscv_aes_result_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .test_en_i      (test_en_i),
    .aes_start_i    (aes_start_i),
    .aes_done_i     (aes_done_i),
    .aes_result_i   (aes_result_i),
    .raddr_i        (raddr_i),
    .ren_i          (ren_i),
    .rdata_o        (rdata_o),
    .rvalid_o       (rvalid_o),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .timeout_o      (timeout_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // Reference model state.
  int          m_state;
  bit [3:0]    m_read;
  bit [127:0]  m_buf;
  bit          m_to;
  int          m_busy_cycles;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_read = 4'b0000;
    m_buf = 128'd0;
    m_to = 1'b0;
    m_busy_cycles = 0;
  endtask

  // Advance the model by one clock cycle with the given inputs.
  task automatic model_step(input bit st, input bit dn, input bit [127:0] res,
                            input bit rn, input bit [1:0] ra, input bit te);
    bit [127:0] nb;
    int         base;
    nb = m_buf;
    base = 127 - 32 * int'(ra);
    if (rn && m_state != M_BUSY) exp_q.push_back(m_buf[base -: 32]);
    if (te) nb = {128{1'b1}};
    else if (m_state == M_BUSY && dn) nb = res;
    case (m_state)
      M_IDLE: begin
        if (st) begin
          m_state = M_BUSY;
          m_read = 4'b0000;
          m_to = 1'b0;
          m_busy_cycles = 0;
        end
      end
      M_BUSY: begin
        m_busy_cycles++;
        if (dn) m_state = M_READY;
        else if (TO_EN && m_busy_cycles == TO_CYCLES) begin
          m_state = M_IDLE;
          m_to = 1'b1;
        end
      end
      default: begin
        if (st) begin
          m_state = M_BUSY;
          m_read = 4'b0000;
          m_to = 1'b0;
          m_busy_cycles = 0;
        end else if (rn) begin
          m_read[ra] = 1'b1;
          if (m_read == 4'b1111) m_state = M_IDLE;
        end
      end
    endcase
    m_buf = nb;
  endtask

  // One cycle: drive after a negedge, check status outputs, step the model, then wait for the next negedge.
  task automatic cyc(input bit st, input bit dn, input bit [127:0] res,
                     input bit rn, input bit [1:0] ra, input bit te);
    aes_start_i = st;
    aes_done_i = dn;
    aes_result_i = res;
    ren_i = rn;
    raddr_i = ra;
    test_en_i = te;
    #1;
    chk("stall", stall_o, rn && m_state == M_BUSY);
    chk("busy", busy_o, m_state == M_BUSY);
    chk("result_valid", result_valid_o, m_state == M_READY);
    chk("timeout", timeout_o, m_to);
    chk("rvalid_missing", exp_q.size(), 0);
    model_step(st, dn, res, rn, ra, te);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd(input bit [1:0] a);
    cyc(1'b0, 1'b0, 128'd0, 1'b1, a, 1'b0);
  endtask

  // Monitor: every read-data pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", 1'b1, 1'b0);
      else chk("rdata", rdata_o, exp_q.pop_front());
    end
  end

  localparam logic [127:0] R1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] R2 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000001;

  initial begin
    rst_n = 1'b0;
    test_en_i = 1'b0; aes_start_i = 1'b0; aes_done_i = 1'b0;
    aes_result_i = 128'd0; ren_i = 1'b0; raddr_i = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_rvalid", rvalid_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_rv", result_valid_o, 1'b0);
    chk("reset_timeout", timeout_o, 1'b0);

    // Read after reset returns zero.
    rd(2'd0);
    idle();

    // Basic result with out-of-order reads; result_valid drops after the 4th read.
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    repeat (9) idle();
    cyc(1'b0, 1'b1, R1, 1'b0, 2'd0, 1'b0);
    rd(2'd3); rd(2'd0); rd(2'd2); rd(2'd1);
    idle();
    chk("rv_dropped", result_valid_o, 1'b0);

    // Read held during BUSY stalls and is accepted the cycle after done.
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    repeat (4) rd(2'd2);
    cyc(1'b0, 1'b1, ~R1, 1'b1, 2'd2, 1'b0);
    rd(2'd2); rd(2'd0); rd(2'd1); rd(2'd3);

    // A restart from READY discards the old result; a read in the same cycle gets the old word.
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, R1, 1'b0, 2'd0, 1'b0);
    rd(2'd0);
    cyc(1'b1, 1'b0, 128'd0, 1'b1, 2'd1, 1'b0);
    idle();
    cyc(1'b0, 1'b1, R2, 1'b0, 2'd0, 1'b0);
    rd(2'd3);
    idle();
    rd(2'd3);

    // Test mode overwrites the buffer without changing the FSM state.
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 2'd0, 1'b1);
    rd(2'd2);
    rd(2'd0); rd(2'd1);
    idle();

    // Watchdog: no done for more than the limit, then done on the last allowed cycle.
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    repeat (70) idle();
    cyc(1'b0, 1'b1, R1, 1'b0, 2'd0, 1'b0);
    idle();
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    repeat (TO_CYCLES - 1) idle();
    cyc(1'b0, 1'b1, R2, 1'b0, 2'd0, 1'b0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
          {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          $urandom_range(0, 39) == 0);
    end
    idle();
    idle();

    // Asynchronous reset while BUSY.
    cyc(1'b1, 1'b0, 128'd0, 1'b0, 2'd0, 1'b0);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_rv", result_valid_o, 1'b0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_rvalid", rvalid_o, 1'b0);
    chk("arst_timeout", timeout_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd1);
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
